// File: rtl/uart_temp_sched.sv
// uart_temp_sched: round-robin scheduler that shares one period-measurement engine and one
// UART frame transmitter between NUM_CH PWM temperature-sensor channels.
//
// Ports:
//   clk, reset         system clock, synchronous active-high reset
//   sched_en_i         scheduler enable
//   chan_en_i          per-channel enable mask (sampled only when a channel is chosen)
//   interval_i         idle clk cycles between measurements
//   meas_sel_o         engine input-mux select
//   meas_start_o       one-cycle measurement start pulse
//   meas_abort_o       one-cycle abort pulse on measurement timeout
//   meas_valid_i       engine count ready (one-cycle pulse)
//   meas_count_i       measured count, valid with meas_valid_i
//   tx_req_o           frame request, held until tx_ack_i
//   tx_ack_i           transmitter accepted the frame
//   tx_done_i          frame fully shifted out (one-cycle pulse)
//   tx_data_o          count to send
//   tx_chan_o          channel id to send
//   tx_err_o           frame carries the timeout marker
//   busy_o             a measurement/transmission is in progress
//
// Optional feature macro: UART_TEMP_SCHED_TIMEOUT_EN enables the measurement timeout
// (abort after TIMEOUT_CYCLES in MEASURE). Without it MEASURE waits indefinitely.
module uart_temp_sched #(
  parameter int unsigned NUM_CH         = 4,
  parameter int unsigned CNT_W          = 32,
  parameter int unsigned INTERVAL_W     = 24,
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      sched_en_i,
  input  logic [NUM_CH-1:0]         chan_en_i,
  input  logic [INTERVAL_W-1:0]     interval_i,
  output logic [$clog2(NUM_CH)-1:0] meas_sel_o,
  output logic                      meas_start_o,
  output logic                      meas_abort_o,
  input  logic                      meas_valid_i,
  input  logic [CNT_W-1:0]          meas_count_i,
  output logic                      tx_req_o,
  input  logic                      tx_ack_i,
  input  logic                      tx_done_i,
  output logic [CNT_W-1:0]          tx_data_o,
  output logic [$clog2(NUM_CH)-1:0] tx_chan_o,
  output logic                      tx_err_o,
  output logic                      busy_o
);

  localparam int unsigned SelW = $clog2(NUM_CH);

  typedef enum logic [2:0] {
    StIdle, StWaitTick, StSelect, StStart, StMeasure, StSend, StWaitDone
  } state_e;

  state_e                state_q, state_d;
  logic [INTERVAL_W-1:0] timer_q, timer_d;
  logic [SelW-1:0]       sel_q, sel_d;
  logic [SelW-1:0]       ptr_q, ptr_d;
  logic [CNT_W-1:0]      data_q, data_d;
  logic [SelW-1:0]       chan_q, chan_d;

`ifdef UART_TEMP_SCHED_TIMEOUT_EN
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            err_q, err_d;
  logic            abort;
`else
  logic unused_timeout;
  assign unused_timeout = ^32'(TIMEOUT_CYCLES);
`endif

  // Next enabled channel strictly after the last-served pointer, wrapping; if only the
  // pointer's own channel is enabled it is served again.
  logic [SelW-1:0] pick;
  logic [SelW:0]   cand;
  logic            found;
  always_comb begin
    pick  = ptr_q;
    found = 1'b0;
    cand  = '0;
    for (int unsigned i = 1; i <= NUM_CH; i++) begin
      cand = {1'b0, ptr_q} + (SelW+1)'(i);
      if (cand >= (SelW+1)'(NUM_CH)) cand = cand - (SelW+1)'(NUM_CH);
      if (!found && chan_en_i[cand[SelW-1:0]]) begin
        pick  = cand[SelW-1:0];
        found = 1'b1;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    timer_d      = timer_q;
    sel_d        = sel_q;
    ptr_d        = ptr_q;
    data_d       = data_q;
    chan_d       = chan_q;
    meas_start_o = 1'b0;
    tx_req_o     = 1'b0;
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
    tmo_d        = tmo_q;
    err_d        = err_q;
    abort        = 1'b0;
`endif
    unique case (state_q)
      StIdle: begin
        if (sched_en_i) begin
          state_d = StWaitTick;
          timer_d = interval_i;
        end
      end
      StWaitTick: begin
        if (!sched_en_i) begin
          state_d = StIdle;
        end else if (timer_q != '0) begin
          timer_d = timer_q - INTERVAL_W'(1);
        end else if (|chan_en_i) begin
          state_d = StSelect;
        end
      end
      StSelect: begin
        sel_d   = pick;
        ptr_d   = pick;
        state_d = StStart;
      end
      StStart: begin
        meas_start_o = 1'b1;
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
        tmo_d        = '0;
`endif
        state_d      = StMeasure;
      end
      StMeasure: begin
        // A count arriving on the timeout cycle takes priority over the abort.
        if (meas_valid_i) begin
          data_d  = meas_count_i;
          chan_d  = sel_q;
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
          err_d   = 1'b0;
`endif
          state_d = StSend;
        end
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
        else if (tmo_q == TmoW'(TIMEOUT_CYCLES - 1)) begin
          abort   = 1'b1;
          data_d  = '1;
          err_d   = 1'b1;
          chan_d  = sel_q;
          state_d = StSend;
        end else begin
          tmo_d = tmo_q + TmoW'(1);
        end
`endif
      end
      StSend: begin
        tx_req_o = 1'b1;
        if (tx_ack_i) begin
          if (tx_done_i) begin
            state_d = StWaitTick;
            timer_d = interval_i;
          end else begin
            state_d = StWaitDone;
          end
        end
      end
      StWaitDone: begin
        if (tx_done_i) begin
          state_d = StWaitTick;
          timer_d = interval_i;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      timer_q <= '0;
      sel_q   <= '0;
      ptr_q   <= SelW'(NUM_CH - 1);
      data_q  <= '0;
      chan_q  <= '0;
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
      tmo_q   <= '0;
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      sel_q   <= sel_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      chan_q  <= chan_d;
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
      tmo_q   <= tmo_d;
      err_q   <= err_d;
`endif
    end
  end

  assign meas_sel_o = sel_q;
  assign tx_data_o  = data_q;
  assign tx_chan_o  = chan_q;
  assign busy_o     = (state_q != StIdle) && (state_q != StWaitTick);
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
  assign meas_abort_o = abort;
  assign tx_err_o     = err_q;
`else
  assign meas_abort_o = 1'b0;
  assign tx_err_o     = 1'b0;
`endif

endmodule

// File: tb/tb_uart_temp_sched.sv
// Self-checking bench for uart_temp_sched (NUM_CH=4, CNT_W=32, TIMEOUT_CYCLES=100).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_uart_temp_sched;

  logic        clk = 1'b0;
  logic        reset;
  logic        sched_en_i;
  logic [3:0]  chan_en_i;
  logic [23:0] interval_i;
  logic [1:0]  meas_sel_o;
  logic        meas_start_o;
  logic        meas_abort_o;
  logic        meas_valid_i;
  logic [31:0] meas_count_i;
  logic        tx_req_o;
  logic        tx_ack_i;
  logic        tx_done_i;
  logic [31:0] tx_data_o;
  logic [1:0]  tx_chan_o;
  logic        tx_err_o;
  logic        busy_o;

  uart_temp_sched #(
    .NUM_CH         (4),
    .CNT_W          (32),
    .INTERVAL_W     (24),
    .TIMEOUT_CYCLES (100)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .sched_en_i   (sched_en_i),
    .chan_en_i    (chan_en_i),
    .interval_i   (interval_i),
    .meas_sel_o   (meas_sel_o),
    .meas_start_o (meas_start_o),
    .meas_abort_o (meas_abort_o),
    .meas_valid_i (meas_valid_i),
    .meas_count_i (meas_count_i),
    .tx_req_o     (tx_req_o),
    .tx_ack_i     (tx_ack_i),
    .tx_done_i    (tx_done_i),
    .tx_data_o    (tx_data_o),
    .tx_chan_o    (tx_chan_o),
    .tx_err_o     (tx_err_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_chk  = 0;
  int n_pass = 0;
  int unsigned done_cyc = 0;  // cycle stamp of the event that reloads the interval timer
  int last_ch;                // reference model: last served channel

  // mask applied before selection, interval loaded before this frame, meas/ack/done delays
  // (dd=0: done with ack), mask written during MEASURE, expected channel
  typedef struct {
    logic [3:0]  mask;
    logic [23:0] iv;
    int          md;
    int          ad;
    int          dd;
    logic [3:0]  mid;
    int          exp_ch;
  } vec_t;

  vec_t tab[12];
  vec_t rnd[20];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic step();
    @(negedge clk);
    meas_valid_i = 1'b0;
    tx_ack_i     = 1'b0;
    tx_done_i    = 1'b0;
  endtask

  // Round-robin rule: first enabled channel after the last served one, wrapping.
  function automatic int next_ch(input logic [3:0] m, input int last);
    for (int k = 1; k <= 4; k++) if (m[(last + k) % 4]) return (last + k) % 4;
    return last;
  endfunction

  task automatic wait_start(input int exp_ch, input int exp_lat);
    int n = 0;
    bit seen = 1'b0;
    while (n < 300 && !seen) begin
      step();
      n++;
      if (meas_start_o) seen = 1'b1;
    end
    chk("start_seen", 64'(seen), 64'd1);
    if (seen) begin
      chk("start_latency", 64'(cyc - done_cyc), 64'(exp_lat));
      chk("meas_sel", 64'(meas_sel_o), 64'(exp_ch));
    end
  endtask

  // Entered at the first SEND cycle; completes ack and done handshakes.
  task automatic handshake(input int ch, input logic [31:0] data, input logic err,
                           input int ad, input int dd, input logic [23:0] nxt_iv);
    int bad = 0;
    chk("tx_req", 64'(tx_req_o), 64'd1);
    chk("tx_data", 64'(tx_data_o), 64'(data));
    chk("tx_chan", 64'(tx_chan_o), 64'(ch));
    chk("tx_err", 64'(tx_err_o), 64'(err));
    chk("busy_send", 64'(busy_o), 64'd1);
    for (int k = 0; k < ad; k++) begin
      step();
      if (tx_req_o !== 1'b1 || tx_data_o !== data || tx_chan_o !== 2'(ch)) bad++;
    end
    if (ad > 0) chk("req_hold_stable", 64'(bad), 64'd0);
    tx_ack_i   = 1'b1;
    interval_i = nxt_iv;
    if (dd == 0) begin
      tx_done_i = 1'b1;
      done_cyc  = cyc;
    end
    step();
    chk("req_drop", 64'(tx_req_o), 64'd0);
    chk("busy_after_ack", 64'(busy_o), (dd == 0) ? 64'd0 : 64'd1);
    if (dd > 0) begin
      for (int k = 0; k < dd - 1; k++) step();
      tx_done_i = 1'b1;
      done_cyc  = cyc;
    end
  endtask

  // Entered at the START cycle; engine answers md cycles later.
  task automatic serve(input int ch, input logic [31:0] cnt, input int md, input int ad,
                       input int dd, input logic [23:0] nxt_iv, input logic [3:0] mid);
    for (int k = 0; k < md; k++) begin
      step();
      if (k == 0 && mid != 4'h0) chan_en_i = mid;
    end
    meas_valid_i = 1'b1;
    meas_count_i = cnt;
    step();
    handshake(ch, cnt, 1'b0, ad, dd, nxt_iv);
  endtask

  initial begin
    #500_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int nb, na, nr, ns, e;

    tab[0]  = '{4'hF, 24'd10, 3, 0, 2, 4'h0, 0};
    tab[1]  = '{4'hF, 24'd10, 5, 1, 1, 4'h0, 1};
    tab[2]  = '{4'hF, 24'd10, 1, 3, 3, 4'h0, 2};
    tab[3]  = '{4'hF, 24'd10, 2, 0, 1, 4'h0, 3};
    tab[4]  = '{4'hF, 24'd10, 4, 0, 1, 4'h0, 0};
    tab[5]  = '{4'h5, 24'd0,  2, 50, 1, 4'h0, 2};
    tab[6]  = '{4'h5, 24'd2,  1, 0, 0, 4'h0, 0};
    tab[7]  = '{4'h5, 24'd0,  1, 0, 0, 4'h8, 2};
    tab[8]  = '{4'h8, 24'd1,  3, 2, 2, 4'h0, 3};
    tab[9]  = '{4'h5, 24'd10, 1, 0, 1, 4'h0, 0};
    tab[10] = '{4'h6, 24'd3,  2, 0, 0, 4'h0, 1};
    tab[11] = '{4'h6, 24'd0,  1, 1, 1, 4'h0, 2};
    for (int i = 0; i < 20; i++) begin
      rnd[i] = '{4'($urandom_range(1, 15)), 24'($urandom_range(0, 5)),
                 int'($urandom_range(1, 4)), int'($urandom_range(0, 3)),
                 int'($urandom_range(0, 2)), 4'h0, 0};
    end

    reset = 1'b1; sched_en_i = 1'b0; chan_en_i = 4'h0; interval_i = '0;
    meas_valid_i = 1'b0; meas_count_i = '0; tx_ack_i = 1'b0; tx_done_i = 1'b0;
    repeat (3) step();
    chk("rst_tx_req", 64'(tx_req_o), 64'd0);
    chk("rst_meas_start", 64'(meas_start_o), 64'd0);
    chk("rst_meas_abort", 64'(meas_abort_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_meas_sel", 64'(meas_sel_o), 64'd0);
    chk("rst_tx_data", 64'(tx_data_o), 64'd0);
    chk("rst_tx_chan", 64'(tx_chan_o), 64'd0);
    chk("rst_tx_err", 64'(tx_err_o), 64'd0);
    reset = 1'b0;
    step();
    chk("idle_no_busy", 64'(busy_o), 64'd0);

    // Table-driven frames: start latency = interval + 3 from the reload event.
    chan_en_i  = tab[0].mask;
    interval_i = tab[0].iv;
    sched_en_i = 1'b1;
    done_cyc   = cyc;
    for (int i = 0; i < 12; i++) begin
      chan_en_i = tab[i].mask;
      wait_start(tab[i].exp_ch, int'(tab[i].iv) + 3);
      serve(tab[i].exp_ch, 32'(tab[i].exp_ch * 1000 + 5), tab[i].md, tab[i].ad, tab[i].dd,
            (i < 11) ? tab[i+1].iv : 24'd0, tab[i].mid);
    end
    last_ch = 2;

    // No channel enabled with the timer expired: nothing starts.
    chan_en_i = 4'h0;
    ns = 0;
    for (int k = 0; k < 1000; k++) begin
      step();
      if (meas_start_o) ns++;
    end
    chk("no_start_while_masked", 64'(ns), 64'd0);
    chk("masked_not_busy", 64'(busy_o), 64'd0);
    chan_en_i = 4'h2;
    step();
    chk("enable_rise_no_start_yet", 64'(meas_start_o), 64'd0);
    step();
    chk("enable_rise_start", 64'(meas_start_o), 64'd1);
    chk("enable_rise_sel", 64'(meas_sel_o), 64'd1);
    serve(1, 32'd1005, 2, 0, 1, 24'd2, 4'h0);
    last_ch = 1;

    // Silent engine.
    chan_en_i = 4'hF;
    wait_start(2, 5);
`ifdef UART_TEMP_SCHED_TIMEOUT_EN
    begin
      int n = 0;
      bit seen = 1'b0;
      while (n < 150 && !seen) begin
        step();
        n++;
        if (meas_abort_o) seen = 1'b1;
      end
      chk("abort_seen", 64'(seen), 64'd1);
      chk("abort_offset", 64'(n), 64'd100);
      step();
      chk("abort_one_cycle", 64'(meas_abort_o), 64'd0);
      handshake(2, 32'hFFFF_FFFF, 1'b1, 0, 1, 24'd3);
    end
`else
    nb = 0; na = 0; nr = 0;
    for (int k = 0; k < 300; k++) begin
      step();
      if (!busy_o) nb++;
      if (meas_abort_o) na++;
      if (tx_req_o) nr++;
    end
    chk("measure_busy_held", 64'(nb), 64'd0);
    chk("no_abort", 64'(na), 64'd0);
    chk("no_req_without_count", 64'(nr), 64'd0);
    meas_valid_i = 1'b1;
    meas_count_i = 32'd7;
    step();
    handshake(2, 32'd7, 1'b0, 0, 1, 24'd3);
`endif
    wait_start(3, 6);
    serve(3, 32'd3005, 2, 0, 1, rnd[0].iv, 4'h0);
    last_ch = 3;

    // Randomised frames against the round-robin model.
    for (int i = 0; i < 20; i++) begin
      chan_en_i = rnd[i].mask;
      e = next_ch(rnd[i].mask, last_ch);
      wait_start(e, int'(rnd[i].iv) + 3);
      serve(e, $urandom, rnd[i].md, rnd[i].ad, rnd[i].dd,
            (i < 19) ? rnd[i+1].iv : 24'd2, 4'h0);
      last_ch = e;
    end

    // Reset while a frame is being requested.
    chan_en_i = 4'hF;
    e = next_ch(4'hF, last_ch);
    wait_start(e, 5);
    step();
    meas_valid_i = 1'b1;
    meas_count_i = 32'hABCD;
    step();
    chk("req_before_reset", 64'(tx_req_o), 64'd1);
    reset = 1'b1;
    step();
    chk("reset_req_drop", 64'(tx_req_o), 64'd0);
    chk("reset_idle", 64'(busy_o), 64'd0);
    chk("reset_sel", 64'(meas_sel_o), 64'd0);
    chk("reset_data", 64'(tx_data_o), 64'd0);
    reset      = 1'b0;
    interval_i = 24'd4;
    done_cyc   = cyc;
    wait_start(0, 7);
    serve(0, 32'd42, 1, 0, 1, 24'd0, 4'h0);
    repeat (3) step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
